slot_code_allocator: RTL and testbench

- Parametrised car-park slot manager. It tracks occupancy of N_SLOTS parking slots.
- On an entry request it allocates the lowest-index free slot and returns that slot's code. On an exit request it frees the slot named by a code.
- It generalises the fixed 16-slot, 4-bit index-to-code mapping to any slot count, with selectable code polarity and registered entry/exit handshakes.
- It sits between the gate controllers and the display/counter logic.

---
 rtl/slot_code_allocator.sv | 89 ++++++++
 tb/tb_slot_code_allocator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/slot_code_allocator.sv
// Car-park slot allocator: grants the lowest free slot on entry, frees a slot by code on exit.
// All responses are registered and appear one cycle after the sampled strobe.
module slot_code_allocator #(
    parameter int N_SLOTS     = 16,
    parameter int CODE_W      = 4,
    parameter int INVERT_CODE = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             entry_req,
    input  logic                             exit_req,
    input  logic [CODE_W-1:0]                exit_code,
    output logic                             entry_ack,
    output logic                             entry_nack,
    output logic [CODE_W-1:0]                entry_code,
    output logic                             exit_ack,
    output logic                             exit_err,
    output logic [N_SLOTS-1:0]               occupancy,
    output logic [$clog2(N_SLOTS+1)-1:0]     free_count,
    output logic                             full,
    output logic                             empty
);

    localparam int FC_W = $clog2(N_SLOTS+1);
    localparam int XW   = CODE_W + 1;

    logic [N_SLOTS-1:0] alloc_mask, exit_mask, occ_nxt;
    logic [CODE_W-1:0]  alloc_code;
    logic [XW-1:0]      exit_ext, exit_idx;
    logic               in_range, entry_ok, exit_ok;
    logic [FC_W-1:0]    fc_nxt;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        alloc_mask = '0;
        alloc_code = '0;
        for (int i = N_SLOTS-1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                alloc_mask    = '0;
                alloc_mask[i] = 1'b1;
                alloc_code    = (INVERT_CODE != 0) ? CODE_W'(N_SLOTS-1-i) : CODE_W'(i);
            end
        end
    end

    // Out-of-range codes may wrap in the inverted decode; in_range masks that off.
    always_comb begin
        exit_ext  = {1'b0, exit_code};
        in_range  = exit_ext <= XW'(N_SLOTS-1);
        exit_idx  = (INVERT_CODE != 0) ? XW'(N_SLOTS-1) - exit_ext : exit_ext;
        exit_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (exit_idx == XW'(i)) exit_mask[i] = 1'b1;
        end
    end

    // Entry and exit see pre-edge occupancy, so the slot being freed is never re-granted.
    always_comb begin
        entry_ok = entry_req && !full;
        exit_ok  = exit_req && in_range && |(exit_mask & occupancy);
        occ_nxt  = (occupancy | (entry_ok ? alloc_mask : '0)) & ~(exit_ok ? exit_mask : '0);
        fc_nxt   = free_count + FC_W'(exit_ok) - FC_W'(entry_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy  <= '0;
            free_count <= FC_W'(N_SLOTS);
            full       <= 1'b0;
            empty      <= 1'b1;
            entry_ack  <= 1'b0;
            entry_nack <= 1'b0;
            entry_code <= '0;
            exit_ack   <= 1'b0;
            exit_err   <= 1'b0;
        end else begin
            occupancy  <= occ_nxt;
            free_count <= fc_nxt;
            full       <= (fc_nxt == '0);
            empty      <= (fc_nxt == FC_W'(N_SLOTS));
            entry_ack  <= entry_ok;
            entry_nack <= entry_req && full;
            if (entry_ok) entry_code <= alloc_code;
            exit_ack   <= exit_ok;
            exit_err   <= exit_req && !exit_ok;
        end
    end

endmodule

// File: tb/tb_slot_code_allocator.sv
// Directed table-driven bench: a 16-slot inverted-code instance and a 10-slot plain-code instance.
module tb_slot_code_allocator;

    typedef struct packed {
        logic        ent;
        logic        ext;
        logic [3:0]  xcode;
        logic        ack;
        logic        nack;
        logic [3:0]  code;
        logic        xack;
        logic        xerr;
        logic [15:0] occ;
        logic [4:0]  fc;
        logic        full;
        logic        empty;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ent_a, ext_a, ack_a, nack_a, xack_a, xerr_a, full_a, empty_a;
    logic [3:0]  xc_a, code_a;
    logic [15:0] occ_a;
    logic [4:0]  fc_a;

    logic        ent_b, ext_b, ack_b, nack_b, xack_b, xerr_b, full_b, empty_b;
    logic [3:0]  xc_b, code_b;
    logic [9:0]  occ_b;
    logic [3:0]  fc_b;

    int errs = 0;
    int checks = 0;

    slot_code_allocator #(.N_SLOTS(16), .CODE_W(4), .INVERT_CODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .entry_req(ent_a), .exit_req(ext_a), .exit_code(xc_a),
        .entry_ack(ack_a), .entry_nack(nack_a), .entry_code(code_a), .exit_ack(xack_a),
        .exit_err(xerr_a), .occupancy(occ_a), .free_count(fc_a), .full(full_a), .empty(empty_a));

    slot_code_allocator #(.N_SLOTS(10), .CODE_W(4), .INVERT_CODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .entry_req(ent_b), .exit_req(ext_b), .exit_code(xc_b),
        .entry_ack(ack_b), .entry_nack(nack_b), .entry_code(code_b), .exit_ack(xack_b),
        .exit_err(xerr_b), .occupancy(occ_b), .free_count(fc_b), .full(full_b), .empty(empty_b));

    function automatic vec_t mk(logic ent, logic ext, logic [3:0] xc, logic ack, logic nack,
                                logic [3:0] code, logic xack, logic xerr, logic [15:0] occ,
                                logic [4:0] fc, logic full, logic empty);
        vec_t v;
        v = '{ent, ext, xc, ack, nack, code, xack, xerr, occ, fc, full, empty};
        return v;
    endfunction

    function automatic string fmt(vec_t v);
        return $sformatf("ack=%b nack=%b code=%h xack=%b xerr=%b occ=%h fc=%0d full=%b empty=%b",
                         v.ack, v.nack, v.code, v.xack, v.xerr, v.occ, v.fc, v.full, v.empty);
    endfunction

    task automatic compare(input string nm, input vec_t g, input vec_t w);
        checks++;
        if (g !== w) begin
            errs++;
            $display("FAIL %s: got %s, want %s", nm, fmt(g), fmt(w));
        end
    endtask

    task automatic check_a(input string nm, input vec_t w);
        vec_t g;
        g = w;
        g.ack = ack_a; g.nack = nack_a; g.code = code_a; g.xack = xack_a; g.xerr = xerr_a;
        g.occ = occ_a; g.fc = fc_a; g.full = full_a; g.empty = empty_a;
        compare(nm, g, w);
    endtask

    task automatic check_b(input string nm, input vec_t w);
        vec_t g;
        g = w;
        g.ack = ack_b; g.nack = nack_b; g.code = code_b; g.xack = xack_b; g.xerr = xerr_b;
        g.occ = {6'b0, occ_b}; g.fc = {1'b0, fc_b}; g.full = full_b; g.empty = empty_b;
        compare(nm, g, w);
    endtask

    task automatic apply_a(input string nm, input vec_t v);
        @(negedge clk);
        ent_a = v.ent; ext_a = v.ext; xc_a = v.xcode;
        @(posedge clk); #1;
        ent_a = 1'b0; ext_a = 1'b0;
        check_a(nm, v);
    endtask

    task automatic apply_b(input string nm, input vec_t v);
        @(negedge clk);
        ent_b = v.ent; ext_b = v.ext; xc_b = v.xcode;
        @(posedge clk); #1;
        ent_b = 1'b0; ext_b = 1'b0;
        check_b(nm, v);
    endtask

    vec_t va[$];
    vec_t vb[$];

    initial begin
        // 16-slot, inverted codes: fill, overflow, free, refill, simultaneous, double free
        for (int i = 0; i < 16; i++)
            va.push_back(mk(1, 0, 4'h0, 1, 0, 4'(15-i), 0, 0, 16'((32'h1 << (i+1)) - 1),
                            5'(15-i), i == 15, 0));
        va.push_back(mk(1, 0, 4'h0, 0, 1, 4'h0, 0, 0, 16'hFFFF, 5'd0, 1, 0));
        va.push_back(mk(0, 1, 4'hD, 0, 0, 4'h0, 1, 0, 16'hFFFB, 5'd1, 0, 0));
        va.push_back(mk(1, 0, 4'h0, 1, 0, 4'hD, 0, 0, 16'hFFFF, 5'd0, 1, 0));
        va.push_back(mk(1, 1, 4'h0, 0, 1, 4'hD, 1, 0, 16'h7FFF, 5'd1, 0, 0));
        va.push_back(mk(0, 1, 4'h0, 0, 0, 4'hD, 0, 1, 16'h7FFF, 5'd1, 0, 0));
        va.push_back(mk(0, 0, 4'h0, 0, 0, 4'hD, 0, 0, 16'h7FFF, 5'd1, 0, 0));

        // 10-slot, plain codes: range errors, allocation order, reuse, net-zero swap
        vb.push_back(mk(0, 1, 4'd12, 0, 0, 4'd0, 0, 1, 16'h000, 5'd10, 0, 1));
        vb.push_back(mk(0, 1, 4'd10, 0, 0, 4'd0, 0, 1, 16'h000, 5'd10, 0, 1));
        vb.push_back(mk(0, 1, 4'd9,  0, 0, 4'd0, 0, 1, 16'h000, 5'd10, 0, 1));
        vb.push_back(mk(1, 0, 4'd0,  1, 0, 4'd0, 0, 0, 16'h001, 5'd9,  0, 0));
        vb.push_back(mk(1, 0, 4'd0,  1, 0, 4'd1, 0, 0, 16'h003, 5'd8,  0, 0));
        vb.push_back(mk(1, 0, 4'd0,  1, 0, 4'd2, 0, 0, 16'h007, 5'd7,  0, 0));
        vb.push_back(mk(0, 1, 4'd1,  0, 0, 4'd2, 1, 0, 16'h005, 5'd8,  0, 0));
        vb.push_back(mk(1, 0, 4'd0,  1, 0, 4'd1, 0, 0, 16'h007, 5'd7,  0, 0));
        vb.push_back(mk(1, 1, 4'd0,  1, 0, 4'd3, 1, 0, 16'h00E, 5'd7,  0, 0));
        vb.push_back(mk(0, 1, 4'd0,  0, 0, 4'd3, 0, 1, 16'h00E, 5'd7,  0, 0));
        vb.push_back(mk(0, 0, 4'd0,  0, 0, 4'd3, 0, 0, 16'h00E, 5'd7,  0, 0));

        rst_n = 1'b0;
        ent_a = 0; ext_a = 0; xc_a = '0;
        ent_b = 0; ext_b = 0; xc_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check_a("reset_a", mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 5'd16, 0, 1));
        check_b("reset_b", mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 5'd10, 0, 1));

        for (int i = 0; i < va.size(); i++) apply_a($sformatf("a_step%0d", i), va[i]);
        for (int i = 0; i < vb.size(); i++) apply_b($sformatf("b_step%0d", i), vb[i]);

        // Mid-stream reset with five slots held and an entry pending
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            apply_a($sformatf("pre_rst%0d", i),
                    mk(1, 0, 4'h0, 1, 0, 4'(15-i), 0, 0, 16'((32'h1 << (i+1)) - 1),
                       5'(15-i), 0, 0));
        @(negedge clk);
        ent_a = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_a("rst_async", mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 5'd16, 0, 1));
        @(posedge clk); #1;
        check_a("rst_held", mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 5'd16, 0, 1));
        @(negedge clk);
        ent_a = 1'b0;
        rst_n = 1'b1;
        apply_a("post_rst_entry", mk(1, 0, 4'h0, 1, 0, 4'hF, 0, 0, 16'h0001, 5'd15, 0, 0));
        apply_a("post_rst_idle",  mk(0, 0, 4'h0, 0, 0, 4'hF, 0, 0, 16'h0001, 5'd15, 0, 0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
